lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Multi-cycle load/store controller that initiates all accesses to the single-port word data RAM. It accepts one decoded load or store from the core and computes the effective address (base + offset). It performs word, halfword and byte accesses, using read-modify-write for sub-word stores, and returns sign- or zero-extended load data with a one-cycle response pulse. It sits between the execute stage and the data RAM, and is the only driver of the RAM's address, data and readWrite inputs.

## Interface
- ADDR_W, 5, RAM word-index width (2^ADDR_W words)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2)
- req_base  in  32  rs1 value
- req_offset  in  32  sign-extended immediate
- req_wdata  in  32  rs2 value (stores)
- resp_valid  out  1  one-cycle completion pulse, no backpressure
- resp_rdata  out  32  extended load data (0 for stores/errors)
- resp_err  out  1  misaligned or illegal funct3, valid with resp_valid
- mem_addr  out  ADDR_W  RAM word index
- mem_readWrite  out  1  1 = read, 0 = write (RAM writes every edge this is 0)
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM registered read data, valid the cycle after a read edge

## Operation
- Effective address: eff = req_base + req_offset mod 2^32. mem_addr = eff[ADDR_W+1:2]. Bits above ADDR_W+1 are ignored, so the address wraps. off = eff[1:0].
- Request, eff, funct3 and wdata are latched on accept (req_valid && req_ready).
- States: IDLE, RD, RDW, WR, RESP.
- IDLE transitions:
  - Error request → RESP with resp_err=1, no RAM access.
  - Load → RD.
  - SW → WR.
  - SB/SH → RD.
- RD: drive mem_addr, mem_readWrite=1 → RDW.
- RDW: sample mem_rdata.
  - Load: extract the byte at lane off or the half at lane off[1], sign-/zero-extend per funct3, latch into resp_rdata → RESP.
  - SB/SH: merge req_wdata[7:0]/[15:0] into the addressed lane, latch into mem_wdata → WR.
- WR: mem_readWrite=0 for exactly one cycle → RESP.
- RESP: resp_valid=1 for one cycle → IDLE.
- Error conditions:
  - LH/LHU/SH with off[0]=1.
  - LW/SW with off≠0.
  - funct3 3/6/7 for loads, ≥3 for stores.
- mem_readWrite is 1 in every state except WR. The RAM must never see a spurious write.
- resp_rdata and resp_err hold their values until the next RESP.

## Timing
- Request accepted at edge k. resp_valid is high between these edges:
  - Load: k+3 and k+4.
  - SW: k+2 and k+3, with the RAM write at edge k+2.
  - SB/SH: k+4 and k+5, with the RAM write at edge k+4.
  - Error: k+1 and k+2.
- req_ready=0 from edge k until return to IDLE. The next accept is possible at the edge after RESP.
- A request held during RESP is not accepted. The requester keeps req_valid high.
- Reset values (asynchronous, on rst_n low): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_wdata=0, mem_readWrite=1.
- Reset asserted during WR forces mem_readWrite=1 immediately. The write is lost if reset precedes the edge.

## Configuration
- LSU_SUBWORD_EN defined:
  - All RV32I widths are supported, including read-modify-write for SB/SH.
- LSU_SUBWORD_EN undefined:
  - Only LW (funct3 2) and SW are legal. Every other funct3 returns resp_err=1 with no RAM access.
  - No lane-extract or merge logic is present.

## Test plan
- SW base=0x10, offset=0x4, wdata=0xDEADBEEF → word 5 written at edge k+2. A following LW at the same address → resp_rdata=0xDEADBEEF at k+3, resp_err=0.
- Word 5=0xDEADBEEF, LB at eff=0x17 → 0xFFFFFFDE. LBU → 0x000000DE. LH at eff=0x16 → 0xFFFFDEAD. LHU at 0x14 → 0x0000BEEF.
- SB wdata=0x55 at eff=0x15 on word 5=0xDEADBEEF → word becomes 0xDEAD55EF. Exactly one cycle has mem_readWrite=0, and resp_valid arrives at k+4.
- LW at eff=0x13 and SH at eff=0x11 → resp_err=1 at k+1, mem_readWrite stays 1 throughout, and RAM contents are unchanged.
- base=0xFFFFFFFC, offset=0x8 → eff=0x4, mem_addr=1 (wrap). base=0x80, offset=0 → mem_addr=0 (ADDR_W=5).
- rst_n pulsed low during WR of an SW → mem_readWrite=1 asynchronously, the word is unchanged, and all outputs are at reset values with req_ready=1. Repeat with LSU_SUBWORD_EN undefined: LB → resp_err=1.

Source files
------------

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store controller driving a single-port word data RAM
// Optional feature macro: LSU_SUBWORD_EN (byte/halfword loads and read-modify-write stores).
// Without it only LW/SW are legal and every other width completes with resp_err.
module lsu_ctrl #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_base,
  input  logic [31:0]       req_offset,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_readWrite,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RDW  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t state, state_nx;

  // pend marks the cycle after accept, still in IDLE, where the latched request is decoded
  logic              pend;
  logic              accept;
  logic              bad;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;
  logic [31:0]       eff;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;
  logic              unused_ok;

  assign eff       = req_base + req_offset;
  assign accept    = req_valid && req_ready;
  // address bits above the RAM index simply wrap
  assign unused_ok = ^eff[31:ADDR_W+2];

  assign mem_addr      = addr_q;
  assign mem_readWrite = rw_q;
  assign mem_wdata     = mem_wdata_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;

  // legality of the latched request: width code and alignment
  always_comb begin
    bad = 1'b0;
`ifdef LSU_SUBWORD_EN
    case (f3_q)
      3'd0:    bad = 1'b0;
      3'd1:    bad = off_q[0];
      3'd2:    bad = (off_q != 2'b00);
      3'd4:    bad = we_q;
      3'd5:    bad = we_q | off_q[0];
      default: bad = 1'b1;
    endcase
`else
    bad = (f3_q != 3'd2) || (off_q != 2'b00);
`endif
  end

`ifdef LSU_SUBWORD_EN
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // lane extraction with sign/zero extension for loads, lane merge for sub-word stores
  always_comb begin
    byte_v     = mem_rdata[{off_q, 3'b000} +: 8];
    half_v     = mem_rdata[{off_q[1], 4'b0000} +: 16];
    load_data  = mem_rdata;
    merge_data = mem_rdata;
    case (f3_q[1:0])
      2'd0:    load_data = {{24{byte_v[7] & ~f3_q[2]}}, byte_v};
      2'd1:    load_data = {{16{half_v[15] & ~f3_q[2]}}, half_v};
      default: load_data = mem_rdata;
    endcase
    if (f3_q[1:0] == 2'd0) begin
      merge_data[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_data[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end
`else
  // word-only build: loads pass the RAM word through, there is no merge path
  always_comb begin
    load_data  = mem_rdata;
    merge_data = wdata_q;
  end
`endif

  // next-state decode and handshake outputs
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = !pend;
        if (pend) begin
          if (bad) begin
            state_nx = S_RESP;
          end else if (we_q && (f3_q == 3'd2)) begin
            state_nx = S_WR;
          end else begin
            state_nx = S_RD;
          end
        end
      end
      S_RD:    state_nx = S_RDW;
      S_RDW:   state_nx = we_q ? S_WR : S_RESP;
      S_WR:    state_nx = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // state register and decode-pending flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pend  <= 1'b0;
    end else begin
      state <= state_nx;
      pend  <= accept;
    end
  end

  // capture the request and its effective address on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      wdata_q <= 32'd0;
      addr_q  <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      off_q   <= eff[1:0];
      wdata_q <= req_wdata;
      addr_q  <= eff[ADDR_W+1:2];
    end
  end

  // registered write strobe so the RAM only ever sees a clean single-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q        <= 1'b1;
      mem_wdata_q <= 32'd0;
    end else begin
      rw_q <= (state_nx != S_WR);
      if (state_nx == S_WR) begin
        mem_wdata_q <= (state == S_RDW) ? merge_data : wdata_q;
      end
    end
  end

  // response data/error, held until the next response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else if (state_nx == S_RESP) begin
      resp_err_q   <= (state == S_IDLE);
      resp_rdata_q <= ((state == S_RDW) && !we_q) ? load_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl with a behavioural RAM and reference model
module tb_lsu_ctrl;

`ifdef LSU_SUBWORD_EN
  localparam bit SUBW = 1'b1;
`else
  localparam bit SUBW = 1'b0;
`endif
  localparam int AW = 5;
  localparam int NV = 18;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_base;
  logic [31:0]   req_offset;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_readWrite;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0] ram [0:31];
  logic [31:0] ref_mem [0:31];
  logic        ram_clr;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_readWrite(mem_readWrite), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // single-port RAM: writes on every edge with readWrite low, registered read otherwise
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 32; i++) ram[i] <= 32'd0;
      mem_rdata <= 32'd0;
    end else if (!mem_readWrite) begin
      ram[mem_addr] <= mem_wdata;
    end else begin
      mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] b, logic [31:0] o,
                              logic [31:0] w, logic [31:0] r, logic e);
    vec_t v;
    v.we = we; v.f3 = f3; v.base = b; v.offset = o; v.wdata = w; v.rdata = r; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: legality from the width/alignment rules
  function automatic bit mdl_err(bit we, logic [2:0] f3, int off);
    if (!SUBW) return !(f3 == 3'd2 && off == 0);
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_load(logic [31:0] word, logic [2:0] f3, int off);
    logic [31:0] sh;
    int          v;
    sh = word >> (8 * off);
    case (f3)
      3'd0: begin v = $signed(sh[7:0]);  return v; end
      3'd1: begin v = $signed(sh[15:0]); return v; end
      3'd4: return sh & 32'h0000_00FF;
      3'd5: return sh & 32'h0000_FFFF;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] mdl_store(logic [31:0] word, logic [2:0] f3, int off,
                                            logic [31:0] wd);
    logic [31:0] mask;
    mask = (f3 == 3'd0) ? 32'h0000_00FF : (f3 == 3'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    return (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
  endfunction

  // issue one request and observe it to completion; cycle c is the negedge after edge k+c
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] base,
                        input logic [31:0] offs, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int wr_cnt, output int wr_edge, output logic [AW-1:0] addr_seen);
    int c;
    rdata = 32'd0; err = 1'b0; lat = -1; wr_cnt = 0; wr_edge = -1; addr_seen = '0;
    c = 0;
    while (!req_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("ready_wait", {31'd0, req_ready}, 32'd1);
    if (!req_ready) return;
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_base = base; req_offset = offs; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    addr_seen = mem_addr;
    for (c = 0; c < 20 && lat < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (!mem_readWrite) begin
        wr_cnt++;
        wr_edge = c + 1;
      end
      if (resp_valid) begin
        lat   = c;
        rdata = resp_rdata;
        err   = resp_err;
        chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
      end
    end
    @(negedge clk);
    chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
  endtask

  // run an op through DUT and model; table entries also supply fixed expected results
  task automatic check_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] base, input logic [31:0] offs, input logic [31:0] wd,
                          input bit use_tbl, input logic [31:0] t_rdata, input logic t_err);
    logic [31:0]   eff, e_rdata, g_rdata;
    logic          g_err;
    logic [AW-1:0] g_addr;
    int            idx, off, g_lat, g_wc, g_we, e_lat, e_we;
    bit            e_err;
    eff   = base + offs;
    idx   = int'(eff >> 2) % 32;
    off   = int'(eff % 4);
    e_err = mdl_err(we, f3, off);
    e_rdata = (!we && !e_err) ? mdl_load(ref_mem[idx], f3, off) : 32'd0;
    if (e_err) e_lat = 1;
    else if (!we) e_lat = 3;
    else if (f3 == 3'd2) e_lat = 2;
    else e_lat = 4;
    e_we = (we && !e_err) ? e_lat : -1;
    run_op(we, f3, base, offs, wd, g_rdata, g_err, g_lat, g_wc, g_we, g_addr);
    if (use_tbl) begin
      chk({tag, "_rdata"}, g_rdata, t_rdata);
      chk({tag, "_err"}, {31'd0, g_err}, {31'd0, t_err});
    end else begin
      chk({tag, "_rdata"}, g_rdata, e_rdata);
      chk({tag, "_err"}, {31'd0, g_err}, {31'd0, e_err});
    end
    chk({tag, "_latency"}, g_lat, e_lat);
    chk({tag, "_write_cycles"}, g_wc, (we && !e_err) ? 1 : 0);
    chk({tag, "_write_edge"}, g_we, e_we);
    if (!e_err) chk({tag, "_mem_addr"}, {27'd0, g_addr}, idx);
    if (we && !e_err) ref_mem[idx] = mdl_store(ref_mem[idx], f3, off, wd);
    chk({tag, "_ram_word"}, ram[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] b, o, e;
    logic [2:0]  f3;
    logic        we;
    int          n;
    bit          seen;

    tbl[0]  = mk(1, 3'd2, 32'h10, 32'h4, 32'hDEADBEEF, 32'h0, 0);
    tbl[1]  = mk(0, 3'd2, 32'h14, 32'h0, 32'h0, 32'hDEADBEEF, 0);
    tbl[2]  = mk(0, 3'd0, 32'h17, 32'h0, 32'h0, SUBW ? 32'hFFFFFFDE : 32'h0, !SUBW);
    tbl[3]  = mk(0, 3'd4, 32'h17, 32'h0, 32'h0, SUBW ? 32'h000000DE : 32'h0, !SUBW);
    tbl[4]  = mk(0, 3'd1, 32'h16, 32'h0, 32'h0, SUBW ? 32'hFFFFDEAD : 32'h0, !SUBW);
    tbl[5]  = mk(0, 3'd5, 32'h14, 32'h0, 32'h0, SUBW ? 32'h0000BEEF : 32'h0, !SUBW);
    tbl[6]  = mk(1, 3'd0, 32'h15, 32'h0, 32'h55, 32'h0, !SUBW);
    tbl[7]  = mk(0, 3'd2, 32'h14, 32'h0, 32'h0, SUBW ? 32'hDEAD55EF : 32'hDEADBEEF, 0);
    tbl[8]  = mk(0, 3'd2, 32'h13, 32'h0, 32'h0, 32'h0, 1);
    tbl[9]  = mk(1, 3'd1, 32'h11, 32'h0, 32'h1234, 32'h0, 1);
    tbl[10] = mk(1, 3'd2, 32'hFFFFFFFC, 32'h8, 32'h12345678, 32'h0, 0);
    tbl[11] = mk(0, 3'd2, 32'h4, 32'h0, 32'h0, 32'h12345678, 0);
    tbl[12] = mk(1, 3'd2, 32'h80, 32'h0, 32'hA5A5A5A5, 32'h0, 0);
    tbl[13] = mk(0, 3'd2, 32'h0, 32'h0, 32'h0, 32'hA5A5A5A5, 0);
    tbl[14] = mk(0, 3'd3, 32'h0, 32'h0, 32'h0, 32'h0, 1);
    tbl[15] = mk(1, 3'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 1);
    tbl[16] = mk(0, 3'd0, 32'h4, 32'h0, 32'h0, SUBW ? 32'h00000078 : 32'h0, !SUBW);
    tbl[17] = mk(0, 3'd1, 32'h8, 32'hFFFFFFFE, 32'h0, SUBW ? 32'h00001234 : 32'h0, !SUBW);

    for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_base = 32'd0; req_offset = 32'd0; req_wdata = 32'd0;
    ram_clr = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_readWrite", {31'd0, mem_readWrite}, 32'd1);
    ram_clr = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      check_op($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].base, tbl[i].offset,
               tbl[i].wdata, 1'b1, tbl[i].rdata, tbl[i].err);
    end

    // reset pulsed during the write cycle of an SW
    check_op("sw_pre", 1'b1, 3'd2, 32'h1C, 32'h0, 32'h11112222, 1'b0, 32'h0, 1'b0);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    req_base = 32'h1C; req_offset = 32'h0; req_wdata = 32'h99999999;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (!mem_readWrite) seen = 1'b1;
    end
    chk("rstwr_reached_wr", {31'd0, seen}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstwr_readWrite_async", {31'd0, mem_readWrite}, 32'd1);
    chk("rstwr_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rstwr_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstwr_resp_rdata", resp_rdata, 32'd0);
    chk("rstwr_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rstwr_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("rstwr_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    chk("rstwr_ram_word", ram[7], ref_mem[7]);
    rst_n = 1'b1;
    @(negedge clk);
    check_op("post_rst_lb", 1'b0, 3'd0, 32'h1C, 32'h1, 32'h0, 1'b0, 32'h0, 1'b0);

    // randomized requests against the reference model
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      b  = $urandom;
      o  = 32'($signed(12'($urandom)));
      if ($urandom_range(0, 3) != 0) begin
        e = b + o;
        if (f3 == 3'd1 || f3 == 3'd5) b = b - (e % 2);
        else if (f3 == 3'd2 || f3 == 3'd3) b = b - (e % 4);
      end
      check_op($sformatf("rnd%0d", i), we, f3, b, o, $urandom, 1'b0, 32'h0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
